// File: rtl/hdmi_vram_defs.sv
// Shared constants for the HDMI VRAM scheduler: register map,
// CTRL/STATUS bits, bus windows, fill FSM encoding.
package hdmi_vram_defs;

   localparam logic [31:0] WIN_MASK  = 32'h00F0_0000;
   localparam logic [31:0] VRAM_BASE = 32'h0020_0000;
   localparam logic [31:0] REG_BASE  = 32'h0030_0000;

   localparam logic [2:0] REG_X0    = 3'd0;
   localparam logic [2:0] REG_Y0    = 3'd1;
   localparam logic [2:0] REG_W     = 3'd2;
   localparam logic [2:0] REG_H     = 3'd3;
   localparam logic [2:0] REG_COLOR = 3'd4;
   localparam logic [2:0] REG_CTRL  = 3'd5;

   localparam int CTRL_START = 0;
   localparam int CTRL_CLEAR = 1;
   localparam int CTRL_ABORT = 2;

   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;

   typedef enum logic [1:0] {
      FILL_IDLE = 2'd0,
      FILL_RUN  = 2'd1,
      FILL_DONE = 2'd2
   } fill_state_t;

   // y * stride as a shift-add chain; only used once per fill start
   function automatic logic [15:0] row_base(
      input logic [7:0]  y,
      input logic [15:0] stride
   );
      logic [15:0] acc;
      acc = '0;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) acc = acc + (stride << i);
      end
      return acc;
   endfunction

endpackage

// File: rtl/hdmi_fill_engine.sv
// Rectangle fill engine: FSM, clipped x/y counters and an
// incremental row-major address generator.
module hdmi_fill_engine
   import hdmi_vram_defs::*;
#(
   parameter int FB_W = 320,
   parameter int FB_H = 180
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic        stall,
   input  logic [8:0]  x0,
   input  logic [7:0]  y0,
   input  logic [8:0]  w,
   input  logic [7:0]  h,
   input  logic [7:0]  color,
   output logic        busy,
   output logic        done,
   output logic        done_set,
   output logic        wr_en,
   output logic [15:0] wr_addr,
   output logic [7:0]  wr_data
);

   localparam logic [9:0]  FBW    = 10'(FB_W);
   localparam logic [8:0]  FBH    = 9'(FB_H);
   localparam logic [15:0] STRIDE = 16'(FB_W);

   fill_state_t state, nxt;

   logic [9:0]  x_cnt, ew;
   logic [8:0]  y_cnt, eh;
   logic [15:0] row_q, addr_q;
   logic [7:0]  color_q;

   logic [9:0]  room_x, eff_w;
   logic [8:0]  room_y, eff_h;
   logic        empty, last_x, last_y;
   logic [15:0] first_addr;

   // clip the requested rectangle against the framebuffer edges
   always_comb begin
      room_x = ({1'b0, x0} < FBW) ? FBW - {1'b0, x0} : '0;
      room_y = ({1'b0, y0} < FBH) ? FBH - {1'b0, y0} : '0;
      eff_w  = ({1'b0, w} < room_x) ? {1'b0, w} : room_x;
      eff_h  = ({1'b0, h} < room_y) ? {1'b0, h} : room_y;
      empty  = (eff_w == '0) || (eff_h == '0);
      first_addr = row_base(y0, STRIDE) + 16'(x0);
   end

   assign last_x = (x_cnt == ew - 10'd1);
   assign last_y = (y_cnt == eh - 9'd1);

   always_comb begin
      nxt   = state;
      busy  = 1'b0;
      done  = 1'b0;
      wr_en = 1'b0;
      unique case (state)
         FILL_IDLE: begin
            if (start) nxt = empty ? FILL_DONE : FILL_RUN;
         end
         FILL_RUN: begin
            busy  = 1'b1;
            wr_en = !stall && !abort;
            if (abort)
               nxt = FILL_DONE;
            else if (wr_en && last_x && last_y)
               nxt = FILL_DONE;
         end
         FILL_DONE: begin
            done = 1'b1;
            nxt  = FILL_IDLE;
         end
         default: nxt = FILL_IDLE;
      endcase
   end

   assign done_set = (nxt == FILL_DONE);
   assign wr_addr  = addr_q;
   assign wr_data  = color_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= FILL_IDLE;
         x_cnt   <= '0;
         y_cnt   <= '0;
         ew      <= '0;
         eh      <= '0;
         row_q   <= '0;
         addr_q  <= '0;
         color_q <= '0;
      end else begin
         state <= nxt;
         if (state == FILL_IDLE && start) begin
            ew      <= eff_w;
            eh      <= eff_h;
            x_cnt   <= '0;
            y_cnt   <= '0;
            row_q   <= first_addr;
            addr_q  <= first_addr;
            color_q <= color;
         end else if (wr_en) begin
            if (last_x) begin
               x_cnt  <= '0;
               y_cnt  <= y_cnt + 9'd1;
               row_q  <= row_q + STRIDE;
               addr_q <= row_q + STRIDE;
            end else begin
               x_cnt  <= x_cnt + 10'd1;
               addr_q <= addr_q + 16'd1;
            end
         end
      end
   end

endmodule

// File: rtl/hdmi_vram_scheduler.sv
// VRAM port-A scheduler: CPU accesses win, the fill engine
// uses idle cycles. Holds the fill register file.
module hdmi_vram_scheduler
   import hdmi_vram_defs::*;
#(
   parameter int XLEN = 32,
   parameter int FB_W = 320,
   parameter int FB_H = 180
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            sel,
   input  logic [XLEN-1:0] addr,
   input  logic [2:0]      we,
   input  logic [XLEN-1:0] qin,
   output logic [XLEN-1:0] qout,
   output logic            vram_en,
   output logic            vram_we,
   output logic [15:0]     vram_addr,
   output logic [7:0]      vram_din,
   input  logic [7:0]      vram_dout,
   output logic            fill_busy,
   output logic            fill_done
);

   logic        vram_hit, reg_hit, reg_wr, reg_rd;
   logic [2:0]  off;
   logic [8:0]  x0_q, w_q;
   logic [7:0]  y0_q, h_q, color_q;
   logic        sticky;
   logic        start, clear, abort;
   logic        done_set, fill_wr;
   logic [15:0] fill_addr;
   logic [7:0]  fill_data;
   logic        rd_vram_q, rd_reg_q;
   logic [XLEN-1:0] rd_val, rd_val_q;

   assign vram_hit = sel && (addr[23:20] == VRAM_BASE[23:20]);
   assign reg_hit  = sel && (addr[23:20] == REG_BASE[23:20]);
   assign off      = addr[4:2];
   assign reg_wr   = reg_hit && (we != 3'b000);
   assign reg_rd   = reg_hit && (we == 3'b000);

   assign start = reg_wr && (off == REG_CTRL) && qin[CTRL_START];
   assign clear = reg_wr && (off == REG_CTRL) && qin[CTRL_CLEAR];
   assign abort = reg_wr && (off == REG_CTRL) && qin[CTRL_ABORT];

   hdmi_fill_engine #(
      .FB_W (FB_W),
      .FB_H (FB_H)
   ) u_fill (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .abort    (abort),
      .stall    (vram_hit),
      .x0       (x0_q),
      .y0       (y0_q),
      .w        (w_q),
      .h        (h_q),
      .color    (color_q),
      .busy     (fill_busy),
      .done     (fill_done),
      .done_set (done_set),
      .wr_en    (fill_wr),
      .wr_addr  (fill_addr),
      .wr_data  (fill_data)
   );

   // CPU owns the port whenever it addresses VRAM
   always_comb begin
      vram_en   = vram_hit || fill_wr;
      vram_we   = vram_hit ? (we == 3'b100) : fill_wr;
      vram_addr = vram_hit ? addr[15:0] : fill_addr;
      vram_din  = vram_hit ? qin[7:0] : fill_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x0_q    <= '0;
         y0_q    <= '0;
         w_q     <= '0;
         h_q     <= '0;
         color_q <= '0;
      end else if (reg_wr) begin
         case (off)
            REG_X0:    x0_q    <= qin[8:0];
            REG_Y0:    y0_q    <= qin[7:0];
            REG_W:     w_q     <= qin[8:0];
            REG_H:     h_q     <= qin[7:0];
            REG_COLOR: color_q <= qin[7:0];
            default:   ;
         endcase
      end
   end

   // a DONE entry in the same cycle as a clear keeps the flag set
   always_ff @(posedge clk) begin
      if (!rst_n)
         sticky <= 1'b0;
      else if (done_set)
         sticky <= 1'b1;
      else if (clear)
         sticky <= 1'b0;
   end

   always_comb begin
      rd_val = '0;
      case (off)
         REG_X0:    rd_val = XLEN'(x0_q);
         REG_Y0:    rd_val = XLEN'(y0_q);
         REG_W:     rd_val = XLEN'(w_q);
         REG_H:     rd_val = XLEN'(h_q);
         REG_COLOR: rd_val = XLEN'(color_q);
         REG_CTRL:  rd_val = XLEN'({sticky, fill_busy});
         default:   rd_val = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_vram_q <= 1'b0;
         rd_reg_q  <= 1'b0;
         rd_val_q  <= '0;
      end else begin
         rd_vram_q <= vram_hit && (we == 3'b000);
         rd_reg_q  <= reg_rd;
         rd_val_q  <= rd_val;
      end
   end

   assign qout = rd_vram_q ? XLEN'(vram_dout) :
                 rd_reg_q  ? rd_val_q : '0;

endmodule

// File: tb/tb_hdmi_vram_scheduler.sv
// Scoreboard bench for hdmi_vram_scheduler: expected VRAM writes
// and read data are queued by stimulus, popped by a monitor.
module tb_hdmi_vram_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sel = 1'b0;
   logic [31:0] addr = '0;
   logic [2:0]  we = '0;
   logic [31:0] qin = '0;
   logic [31:0] qout;
   logic        vram_en, vram_we;
   logic [15:0] vram_addr;
   logic [7:0]  vram_din;
   logic [7:0]  vram_dout;
   logic        fill_busy, fill_done;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   logic rd_flag = 1'b0;

   logic [23:0] exp_wr[$];
   logic [31:0] exp_rd[$];
   bit   [7:0]  mem [0:65535];

   hdmi_vram_scheduler #(
      .XLEN (32),
      .FB_W (320),
      .FB_H (180)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sel       (sel),
      .addr      (addr),
      .we        (we),
      .qin       (qin),
      .qout      (qout),
      .vram_en   (vram_en),
      .vram_we   (vram_we),
      .vram_addr (vram_addr),
      .vram_din  (vram_din),
      .vram_dout (vram_dout),
      .fill_busy (fill_busy),
      .fill_done (fill_done)
   );

   always #5 clk = ~clk;

   // behavioural VRAM with one cycle read latency
   always @(posedge clk) begin
      if (vram_en) begin
         if (vram_we) mem[vram_addr] <= vram_din;
         vram_dout <= mem[vram_addr];
      end
   end

   always @(posedge clk)
      rd_flag <= rst_n && sel && (we == 3'b000) &&
                 (addr[23:20] == 4'h2 || addr[23:20] == 4'h3);

   always @(negedge clk) begin
      logic [31:0] er;
      logic [23:0] ew;
      if (rd_flag) begin
         checks++;
         if (exp_rd.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected: qout=%0h, no read expected", qout);
         end else begin
            er = exp_rd.pop_front();
            if (qout !== er) begin
               errors++;
               $display("FAIL rd_data: qout=%0h expected %0h", qout, er);
            end
         end
      end
      if (vram_en && vram_we) begin
         checks++;
         if (exp_wr.size() == 0) begin
            errors++;
            $display("FAIL wr_unexpected: addr=%0d din=%0h",
                     vram_addr, vram_din);
         end else begin
            ew = exp_wr.pop_front();
            if ({vram_addr, vram_din} !== ew) begin
               errors++;
               $display("FAIL wr_data: addr=%0d din=%0h expected addr=%0d din=%0h",
                        vram_addr, vram_din, ew[23:8], ew[7:0]);
            end
         end
      end
      if (fill_done) begin
         done_cnt++;
         checks++;
         if (exp_wr.size() != 0) begin
            errors++;
            $display("FAIL done_early: %0d writes outstanding, expected 0",
                     exp_wr.size());
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus(input logic [31:0] a, input logic [2:0] w,
                      input logic [31:0] d);
      sel = 1'b1;
      addr = a;
      we = w;
      qin = d;
      @(posedge clk);
      #1;
      sel = 1'b0;
      addr = '0;
      we = '0;
      qin = '0;
   endtask

   task automatic reg_wr(input int off, input logic [31:0] v);
      bus(32'h0030_0000 | 32'(off << 2), 3'b111, v);
   endtask

   task automatic reg_rd(input int off, input logic [31:0] e);
      exp_rd.push_back(e);
      bus(32'h0030_0000 | 32'(off << 2), 3'b000, '0);
   endtask

   task automatic cpu_vwr(input logic [15:0] a, input logic [7:0] d);
      exp_wr.push_back({a, d});
      bus(32'h0020_0000 | 32'(a), 3'b100, 32'(d));
   endtask

   task automatic cpu_vrd(input logic [15:0] a, input logic [7:0] e);
      exp_rd.push_back(32'(e));
      bus(32'h0020_0000 | 32'(a), 3'b000, '0);
   endtask

   task automatic setup(input int x, input int y, input int w,
                        input int h, input int c);
      reg_wr(0, 32'(x));
      reg_wr(1, 32'(y));
      reg_wr(2, 32'(w));
      reg_wr(3, 32'(h));
      reg_wr(4, 32'(c));
   endtask

   task automatic push_run(input int base, input int n, input int c);
      for (int i = 0; i < n; i++)
         exp_wr.push_back({16'(base + i), 8'(c)});
   endtask

   task automatic wait_done(input int lim, input string name);
      int n0;
      int k;
      n0 = done_cnt;
      k = 0;
      while (done_cnt == n0 && k < lim) begin
         @(posedge clk);
         k++;
      end
      #1;
      checks++;
      if (done_cnt == n0) begin
         errors++;
         $display("FAIL %s: no fill_done within %0d cycles", name, lim);
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic outputs_zero(input string tag);
      @(negedge clk);
      chk({tag, "_vram_en"}, 32'(vram_en), 0);
      chk({tag, "_vram_we"}, 32'(vram_we), 0);
      chk({tag, "_busy"}, 32'(fill_busy), 0);
      chk({tag, "_done"}, 32'(fill_done), 0);
      chk({tag, "_qout"}, qout, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int d0;
      step(2);
      rst_n = 1'b1;
      outputs_zero("reset");
      reg_rd(5, 0);

      // basic 4x2 fill
      setup(10, 5, 4, 2, 8'hAA);
      reg_rd(0, 10);
      reg_rd(2, 4);
      push_run(1610, 4, 8'hAA);
      push_run(1930, 4, 8'hAA);
      reg_wr(5, 1);
      reg_rd(5, 1);
      wait_done(20, "fill_basic");
      reg_rd(5, 2);
      chk("basic_drained", 32'(exp_wr.size()), 0);
      reg_wr(5, 2);
      reg_rd(5, 0);

      // CPU write steals the 3rd fill cycle; W write and re-start ignored
      push_run(1610, 2, 8'hAA);
      exp_wr.push_back({16'd5, 8'h55});
      push_run(1612, 2, 8'hAA);
      push_run(1930, 4, 8'hAA);
      reg_wr(5, 1);
      step(2);
      bus(32'h0020_0005, 3'b100, 32'h55);
      reg_wr(2, 50);
      reg_wr(5, 1);
      wait_done(20, "fill_stall");
      chk("stall_drained", 32'(exp_wr.size()), 0);
      cpu_vrd(16'd5, 8'h55);
      cpu_vrd(16'd1933, 8'hAA);
      reg_rd(2, 50);
      reg_wr(5, 2);

      // bottom-right corner clipping
      setup(318, 179, 10, 10, 8'h3C);
      push_run(57598, 2, 8'h3C);
      reg_wr(5, 1);
      wait_done(10, "fill_clip");
      chk("clip_drained", 32'(exp_wr.size()), 0);

      // empty fills finish one cycle after start
      setup(0, 0, 0, 5, 8'h77);
      reg_wr(5, 1);
      wait_done(1, "fill_w0");
      setup(320, 0, 5, 5, 8'h77);
      reg_wr(5, 1);
      wait_done(1, "fill_x0_out");
      cpu_vwr(16'd100, 8'h9E);
      cpu_vrd(16'd100, 8'h9E);

      // abort after three writes
      reg_wr(5, 2);
      setup(0, 0, 100, 1, 8'h11);
      push_run(0, 3, 8'h11);
      reg_wr(5, 1);
      step(3);
      reg_wr(5, 4);
      wait_done(3, "fill_abort");
      reg_rd(5, 2);
      chk("abort_drained", 32'(exp_wr.size()), 0);

      // reset mid-fill: the write in the reset cycle itself still lands
      reg_wr(5, 2);
      push_run(0, 4, 8'h11);
      d0 = done_cnt;
      reg_wr(5, 1);
      step(3);
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      outputs_zero("midreset");
      step(10);
      chk("midreset_no_done", 32'(done_cnt), 32'(d0));
      chk("midreset_drained", 32'(exp_wr.size()), 0);
      reg_rd(2, 0);
      reg_rd(5, 0);
      step(2);
      chk("rd_drained", 32'(exp_rd.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
